// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// so in_ready is registered and never depends combinationally on out_ready.
module pipe_stage_elastic #(
  parameter int            DW            = 32,
  parameter logic [DW-1:0] RESET_VAL     = '0,
  parameter bit            ZERO_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  // Encoding mirrors {s_v, m_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] m_d_q, m_d_d;
  logic [DW-1:0] s_d_q, s_d_d;
  logic          m_v, s_v;
  logic          acc, pop;

  assign m_v       = state_q[0];
  assign s_v       = state_q[1];
  assign out_valid = m_v;
  assign out_data  = m_d_q;
  assign in_ready  = ~s_v;
  assign count     = {1'b0, m_v} + {1'b0, s_v};

  assign acc = in_valid & in_ready;
  assign pop = m_v & out_ready;

  always_comb begin
    state_d = state_q;
    m_d_d   = m_d_q;
    s_d_d   = s_d_q;
    if (flush) begin
      // Anything accepted this cycle is dropped along with the held entries.
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        m_d_d = RESET_VAL;
        s_d_d = RESET_VAL;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            m_d_d   = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_d_d = in_data;
          end else if (acc) begin
            s_d_d   = in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            m_d_d   = s_d_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      m_d_q   <= RESET_VAL;
      s_d_q   <= RESET_VAL;
    end else begin
      state_q <= state_d;
      m_d_q   <= m_d_d;
      s_d_q   <= s_d_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, a ZERO_ON_FLUSH=0
// sequence, and a randomized run against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int W = 66;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: DW=66, flush clears payload
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  pipe_stage_elastic #(.DW(W), .RESET_VAL('0), .ZERO_ON_FLUSH(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  // Second DUT: DW=32, flush keeps payload
  logic        r0, f0, iv0, or0;
  logic [31:0] d0;
  logic        ir0, ov0;
  logic [31:0] od0;
  logic [1:0]  c0;

  pipe_stage_elastic #(.DW(32), .RESET_VAL('0), .ZERO_ON_FLUSH(1'b0)) u_dut0 (
    .clk(clk), .reset(r0), .flush(f0),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .count(c0)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic         rst, fl, iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         ov, ir;
    logic [1:0]   cnt;
    logic [W-1:0] od;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [W-1:0] din, input logic ordy,
                              input logic ov, input logic ir, input logic [1:0] cnt,
                              input logic [W-1:0] od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.od = od;
    return v;
  endfunction

  // Reference model: the stage is a FIFO of at most two entries
  logic [W-1:0] q[$];

  initial begin
    logic [95:0]  rnd;
    logic [W-1:0] exp_front;
    logic         stall;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    r0 = 1'b1; f0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; d0 = '0;

    // Reset with an entry offered
    tbl.push_back(mk(1, 0, 1, 66'hDEAD_BEEF, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 66'hDEAD_BEEF, 0,  0, 1, 0, 0));
    // Streaming 1..8
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 0, 1, W'(i), 1,  1, 1, 1, W'(i)));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, 8));
    // Backpressure A, B, C
    tbl.push_back(mk(0, 0, 1, 'hA, 0,  1, 1, 1, 'hA));
    tbl.push_back(mk(0, 0, 1, 'hB, 0,  1, 0, 2, 'hA));
    tbl.push_back(mk(0, 0, 1, 'hC, 0,  1, 0, 2, 'hA));
    tbl.push_back(mk(0, 0, 1, 'hC, 0,  1, 0, 2, 'hA));
    tbl.push_back(mk(0, 0, 1, 'hC, 1,  1, 1, 1, 'hB));
    tbl.push_back(mk(0, 0, 1, 'hC, 1,  1, 1, 1, 'hC));
    tbl.push_back(mk(0, 0, 0, 0,   1,  0, 1, 0, 'hC));
    // Flush while FULL, with an entry offered in the flush cycle
    tbl.push_back(mk(0, 0, 1, 'h11, 0,  1, 1, 1, 'h11));
    tbl.push_back(mk(0, 0, 1, 'h22, 0,  1, 0, 2, 'h11));
    tbl.push_back(mk(0, 1, 1, 'h33, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h44, 1,  1, 1, 1, 'h44));
    // Reset while FULL
    tbl.push_back(mk(0, 0, 1, 'h45, 0,  1, 0, 2, 'h44));
    tbl.push_back(mk(1, 0, 1, 'h77, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
      in_data = tbl[i].din; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d.out_valid", i), W'(out_valid), W'(tbl[i].ov));
      chk($sformatf("v%0d.in_ready", i),  W'(in_ready),  W'(tbl[i].ir));
      chk($sformatf("v%0d.count", i),     W'(count),     W'(tbl[i].cnt));
      chk($sformatf("v%0d.out_data", i),  out_data,      tbl[i].od);
    end
    in_valid = 1'b0;

    // ZERO_ON_FLUSH=0: payload survives flush
    r0 = 1'b0; iv0 = 1'b1; d0 = 32'h55;
    @(posedge clk); #1;
    chk("z0.load_valid", W'(ov0), 1);
    chk("z0.load_data",  W'(od0), 'h55);
    iv0 = 1'b0; f0 = 1'b1;
    @(posedge clk); #1;
    chk("z0.flush_valid", W'(ov0), 0);
    chk("z0.flush_count", W'(c0), 0);
    chk("z0.flush_data",  W'(od0), 'h55);
    chk("z0.flush_ready", W'(ir0), 1);
    f0 = 1'b0; iv0 = 1'b1; d0 = 32'h66;
    @(posedge clk); #1;
    chk("z0.next_valid", W'(ov0), 1);
    chk("z0.next_data",  W'(od0), 'h66);
    iv0 = 1'b0;

    // Randomized run against the FIFO model
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rnd       = {$urandom(), $urandom(), $urandom()};
      in_data   = rnd[W-1:0];
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 199) == 0);
      stall     = (q.size() > 0) && !out_ready && !flush;
      exp_front = (q.size() > 0) ? q[0] : '0;
      if (flush) begin
        q.delete();
      end else begin
        logic can_take;
        can_take = (q.size() < 2);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && can_take) q.push_back(in_data);
      end
      @(posedge clk); #1;
      chk("rnd.out_valid", W'(out_valid), W'(q.size() > 0));
      chk("rnd.in_ready",  W'(in_ready),  W'(q.size() < 2));
      chk("rnd.count",     W'(count),     W'(q.size()));
      chk("rnd.count_le2", W'(count <= 2'd2), 1);
      if (q.size() > 0) chk("rnd.out_data", out_data, q[0]);
      if (stall) chk("rnd.stable", out_data, exp_front);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
